// File: rtl/io_pkg.sv
// Shared types and constants for the IO input-conditioning blocks.
package io_pkg;

  typedef enum logic [0:0] {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } io_deb_state_e;

  localparam int GLITCH_CNT_W = 8;

  localparam int SYS_CLK_HZ = 1_000_000;

  // One millisecond of qualification at the system clock.
  localparam int DEBOUNCE_1MS_CYCLES = SYS_CLK_HZ / 1000;

endpackage : io_pkg

// File: rtl/io_sat_counter.sv
// Generic up-counter that sticks at all-ones; clear wins over increment.
module io_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : io_sat_counter

// File: rtl/io_debounce.sv
// Debounces one synchronized pin level and emits rise/fall event pulses.
// Optional glitch counter enabled by defining IO_DEBOUNCE_GLITCH_CNT_EN.
module io_debounce
  import io_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_1MS_CYCLES,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  input  logic enable,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
`ifdef IO_DEBOUNCE_GLITCH_CNT_EN
  ,
  input  logic                    glitch_clr,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  io_deb_state_e    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;
  logic             busy_q;

  // Qualification FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (!enable) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        STABLE: begin
          if (data_in == level_q) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (DEBOUNCE_CYCLES == 1) begin
            level_q <= ~level_q;
            rise_q  <= ~level_q;
            fall_q  <= level_q;
            cnt_q   <= '0;
            state_q <= STABLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= CNT_ONE;
            state_q <= QUALIFY;
            busy_q  <= 1'b1;
          end
        end
        QUALIFY: begin
          // A return to the committed level aborts, even on the terminal count.
          if (data_in == level_q) begin
            cnt_q   <= '0;
            state_q <= STABLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            level_q <= ~level_q;
            rise_q  <= ~level_q;
            fall_q  <= level_q;
            cnt_q   <= '0;
            state_q <= STABLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
            state_q <= QUALIFY;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= STABLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign busy  = busy_q;

`ifdef IO_DEBOUNCE_GLITCH_CNT_EN
  logic abort_s;

  assign abort_s = !rst && enable && (state_q == QUALIFY) && (data_in == level_q);

  io_sat_counter #(
    .W(GLITCH_CNT_W)
  ) u_glitch_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (glitch_clr),
    .inc_i (abort_s),
    .cnt_o (glitch_cnt)
  );
`endif

endmodule : io_debounce

// File: tb/tb_io_debounce.sv
// Scoreboard bench for io_debounce: three configurations driven together.
module tb_io_debounce;

  localparam int NI = 3;
  localparam int DCS [NI] = '{4, 4, 1};
  localparam logic RLS [NI] = '{1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst_v = '1;
  logic [NI-1:0] en_v  = '1;
  logic [NI-1:0] din_v = '0;
  logic [NI-1:0] clr_v = '0;
  logic [NI-1:0] lvl_v, rise_v, fall_v, busy_v;
  logic [7:0]    gcnt_v [NI];

  io_debounce #(.DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0)) dut0 (
    .clk(clk), .rst(rst_v[0]), .data_in(din_v[0]), .enable(en_v[0]),
    .level(lvl_v[0]), .rise(rise_v[0]), .fall(fall_v[0]), .busy(busy_v[0])
`ifdef IO_DEBOUNCE_GLITCH_CNT_EN
    , .glitch_clr(clr_v[0]), .glitch_cnt(gcnt_v[0])
`endif
  );

  io_debounce #(.DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b1)) dut1 (
    .clk(clk), .rst(rst_v[1]), .data_in(din_v[1]), .enable(en_v[1]),
    .level(lvl_v[1]), .rise(rise_v[1]), .fall(fall_v[1]), .busy(busy_v[1])
`ifdef IO_DEBOUNCE_GLITCH_CNT_EN
    , .glitch_clr(clr_v[1]), .glitch_cnt(gcnt_v[1])
`endif
  );

  io_debounce #(.DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0)) dut2 (
    .clk(clk), .rst(rst_v[2]), .data_in(din_v[2]), .enable(en_v[2]),
    .level(lvl_v[2]), .rise(rise_v[2]), .fall(fall_v[2]), .busy(busy_v[2])
`ifdef IO_DEBOUNCE_GLITCH_CNT_EN
    , .glitch_clr(clr_v[2]), .glitch_cnt(gcnt_v[2])
`endif
  );

  typedef struct {
    int   tag;
    int   idx;
    logic level;
    logic rise;
    logic fall;
    logic busy;
    int   g;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_step = 0;

  // Reference model: level flips once the input has differed for DC edges in a row.
  logic m_level [NI];
  int   m_run   [NI];
  int   m_g     [NI];

  logic [NI-1:0] cur_r = '1, cur_e = '1, cur_d = '0, cur_c = '0;

  task automatic chk(input string name, input int idx, input int tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s inst%0d edge %0d: got %0d expected %0d", name, idx, tag, got, want);
    end
  endtask

  task automatic step();
    rst_v = cur_r; en_v = cur_e; din_v = cur_d; clr_v = cur_c;
    n_step++;
    for (int i = 0; i < NI; i++) begin
      exp_t x;
      logic rz, fz, ab;
      rz = 1'b0; fz = 1'b0; ab = 1'b0;
      if (cur_r[i]) begin
        m_level[i] = RLS[i]; m_run[i] = 0;
      end else if (!cur_e[i]) begin
        m_run[i] = 0;
      end else if (cur_d[i] == m_level[i]) begin
        ab = (m_run[i] > 0); m_run[i] = 0;
      end else begin
        m_run[i]++;
        if (m_run[i] == DCS[i]) begin
          rz = cur_d[i]; fz = !cur_d[i]; m_level[i] = cur_d[i]; m_run[i] = 0;
        end
      end
      if (cur_r[i] || cur_c[i]) m_g[i] = 0;
      else if (ab && m_g[i] < 255) m_g[i]++;
      x.tag = n_step; x.idx = i; x.level = m_level[i]; x.rise = rz; x.fall = fz;
      x.busy = (m_run[i] > 0); x.g = m_g[i];
      q.push_back(x);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Monitor: after each edge, compare every expectation queued for that edge.
  initial begin
    int seen;
    seen = 0;
    forever begin
      @(posedge clk);
      seen++;
      @(negedge clk);
      while (q.size() > 0 && q[0].tag <= seen) begin
        exp_t x;
        x = q.pop_front();
        chk("level", x.idx, x.tag, int'(lvl_v[x.idx]), int'(x.level));
        chk("rise",  x.idx, x.tag, int'(rise_v[x.idx]), int'(x.rise));
        chk("fall",  x.idx, x.tag, int'(fall_v[x.idx]), int'(x.fall));
        chk("busy",  x.idx, x.tag, int'(busy_v[x.idx]), int'(x.busy));
`ifdef IO_DEBOUNCE_GLITCH_CNT_EN
        chk("glitch_cnt", x.idx, x.tag, int'(gcnt_v[x.idx]), x.g);
`endif
      end
    end
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_level[i] = RLS[i]; m_run[i] = 0; m_g[i] = 0;
    end
    cur_r = 3'b111; cur_e = 3'b111; cur_d = 3'b010; cur_c = 3'b000;
    tick(3);
    cur_r = 3'b000;
    tick(3);
    // Glitch on inst0, toggles on inst2.
    cur_d[0] = 1'b1; cur_d[2] = 1'b1; tick(1);
    cur_d[2] = 1'b0; tick(1);
    cur_d[2] = 1'b1; tick(1);
    cur_d[0] = 1'b0; cur_d[2] = 1'b0; tick(2);
    // Clean rise then clean fall.
    cur_d[0] = 1'b1; cur_d[1] = 1'b0; tick(6);
    cur_d[0] = 1'b0; cur_d[1] = 1'b1; tick(6);
    // Reset mid-qualification.
    cur_d[0] = 1'b1; tick(2);
    cur_r[0] = 1'b1; tick(1);
    cur_r[0] = 1'b0; tick(6);
    // Enable dropped mid-qualification, then a full restart.
    cur_d[0] = 1'b0; tick(2);
    cur_e[0] = 1'b0; tick(2);
    cur_e[0] = 1'b1; tick(5);
    // Saturate the glitch counter, then clear coincident with a glitch.
    for (int k = 0; k < 300; k++) begin
      cur_d[0] = 1'b1; tick(1);
      cur_d[0] = 1'b0; tick(1);
    end
    cur_d[0] = 1'b1; tick(1);
    cur_d[0] = 1'b0; cur_c[0] = 1'b1; tick(1);
    cur_c[0] = 1'b0; tick(2);
    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NI; i++) begin
        cur_r[i] = ($urandom_range(63) == 0);
        cur_e[i] = ($urandom_range(7) != 0);
        cur_c[i] = ($urandom_range(31) == 0);
        if ($urandom_range(5) == 0) cur_d[i] = ~cur_d[i];
      end
      step();
    end
    cur_r = '0; cur_e = '1; cur_c = '0;
    tick(6);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 0, n_step, q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_io_debounce
